// File: rtl/rv32_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32_fetch_pkg
// Brief    : Shared fetch-packet type and pointer/count width helpers.
// Revision : 1.0 - initial release
// ============================================================================
package rv32_fetch_pkg;

   localparam int unsigned c_PC_WIDTH    = 32;
   localparam int unsigned c_INSTR_WIDTH = 32;
   localparam int unsigned c_CAUSE_WIDTH = 4;

   typedef struct packed {
      logic [c_PC_WIDTH-1:0]    pc;
      logic [c_INSTR_WIDTH-1:0] instr;
      logic                     exception;
      logic [c_CAUSE_WIDTH-1:0] exception_cause;
      logic                     branch_predicted_taken;
   } rv32_fetch_packet_t;

   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rv32_fetch_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : rv32_fetch_buffer_if
// Brief    : Fetch-side and decode-side handshake bundle of the fetch buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface rv32_fetch_buffer_if
   import rv32_fetch_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned PC_WIDTH = c_PC_WIDTH
);
   localparam int unsigned c_CNT_W = cnt_width(DEPTH);

   logic                     flush_in;
   logic                     valid_in;
   logic                     ready_out;
   logic [PC_WIDTH-1:0]      pc_in;
   logic [c_INSTR_WIDTH-1:0] instr_in;
   logic                     exception_in;
   logic [c_CAUSE_WIDTH-1:0] exception_cause_in;
   logic                     branch_predicted_taken_in;

   logic                     valid_out;
   logic                     ready_in;
   logic [PC_WIDTH-1:0]      pc_out;
   logic [c_INSTR_WIDTH-1:0] instr_out;
   logic                     exception_out;
   logic [c_CAUSE_WIDTH-1:0] exception_cause_out;
   logic                     branch_predicted_taken_out;
   logic [c_CNT_W-1:0]       count_out;
   logic                     empty_out;
   logic                     full_out;

   modport slave (
      input  flush_in, valid_in, pc_in, instr_in, exception_in,
             exception_cause_in, branch_predicted_taken_in, ready_in,
      output ready_out, valid_out, pc_out, instr_out, exception_out,
             exception_cause_out, branch_predicted_taken_out,
             count_out, empty_out, full_out
   );

   modport master (
      output flush_in, valid_in, pc_in, instr_in, exception_in,
             exception_cause_in, branch_predicted_taken_in, ready_in,
      input  ready_out, valid_out, pc_out, instr_out, exception_out,
             exception_cause_out, branch_predicted_taken_out,
             count_out, empty_out, full_out
   );

endinterface
`default_nettype wire

// File: rtl/rv32_fetch_buffer_mem.sv
`default_nettype none
// ============================================================================
// Module   : rv32_fetch_buffer_mem
// Brief    : DEPTH x WIDTH packet storage, synchronous write, async read.
// Revision : 1.0 - initial release
// ============================================================================
module rv32_fetch_buffer_mem #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned WIDTH  = 70,
   parameter int unsigned ADDR_W = 2
) (
   input  logic              clk,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [WIDTH-1:0]  i_wr_data,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [WIDTH-1:0]  o_rd_data
);

   // Storage is deliberately left unreset; the top masks stale entries.
   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/rv32_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : rv32_fetch_buffer
// Brief    : DEPTH-entry fetch-to-decode packet FIFO with flush; optional
//            zero-latency bypass when RV32_FETCH_BUFFER_BYPASS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module rv32_fetch_buffer
   import rv32_fetch_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned PC_WIDTH = c_PC_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   rv32_fetch_buffer_if.slave bus
);

   localparam int unsigned        c_PTR_W    = ptr_width(DEPTH);
   localparam int unsigned        c_CNT_W    = cnt_width(DEPTH);
   localparam int unsigned        c_PKT_W    = PC_WIDTH + c_INSTR_WIDTH + c_CAUSE_WIDTH + 2;
   localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);
   localparam logic [c_CNT_W-1:0] c_ONE_CNT  = c_CNT_W'(1);
   localparam logic [c_PTR_W-1:0] c_ONE_PTR  = c_PTR_W'(1);

   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;

   logic               w_empty;
   logic               w_full;
   logic               w_valid_out;
   logic               w_bypass_sel;
   logic               w_push;
   logic               w_pop;
   logic               w_store;
   logic               w_unload;
   logic [c_PKT_W-1:0] w_in_pkt;
   logic [c_PKT_W-1:0] w_mem_pkt;
   logic [c_PKT_W-1:0] w_head_pkt;

   assign w_empty  = (r_count == '0);
   assign w_full   = (r_count == c_FULL_CNT);
   assign w_in_pkt = {bus.pc_in, bus.instr_in, bus.exception_in,
                      bus.exception_cause_in, bus.branch_predicted_taken_in};

`ifdef RV32_FETCH_BUFFER_BYPASS_EN
   // The cycle right after a flush must show no packet, so bypass waits a cycle.
   logic r_flush_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_flush_q <= 1'b0;
      end else begin
         r_flush_q <= bus.flush_in;
      end
   end

   assign w_bypass_sel = w_empty && !bus.flush_in && !r_flush_q;
   assign w_valid_out  = w_bypass_sel ? bus.valid_in : (!w_empty && !bus.flush_in);
   assign w_head_pkt   = w_bypass_sel ? w_in_pkt : w_mem_pkt;
`else
   assign w_bypass_sel = 1'b0;
   assign w_valid_out  = !w_empty && !bus.flush_in;
   assign w_head_pkt   = w_mem_pkt;
`endif

   assign w_push   = bus.valid_in && !w_full && !bus.flush_in;
   assign w_pop    = w_valid_out && bus.ready_in && !bus.flush_in;
   // A bypassed packet taken by decode in the same cycle never enters storage.
   assign w_store  = w_push && !(w_bypass_sel && w_pop);
   assign w_unload = w_pop && !w_bypass_sel;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (bus.flush_in) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_store) begin
            r_wr_ptr <= r_wr_ptr + c_ONE_PTR;
         end
         if (w_unload) begin
            r_rd_ptr <= r_rd_ptr + c_ONE_PTR;
         end
         case ({w_store, w_unload})
            2'b10:   r_count <= r_count + c_ONE_CNT;
            2'b01:   r_count <= r_count - c_ONE_CNT;
            default: r_count <= r_count;
         endcase
      end
   end

   rv32_fetch_buffer_mem #(
      .DEPTH  (DEPTH),
      .WIDTH  (c_PKT_W),
      .ADDR_W (c_PTR_W)
   ) u_mem (
      .clk       (clk),
      .i_wr_en   (w_store),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (w_in_pkt),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (w_mem_pkt)
   );

   assign bus.ready_out = !w_full;
   assign bus.valid_out = w_valid_out;
   assign bus.count_out = r_count;
   assign bus.empty_out = w_empty;
   assign bus.full_out  = w_full;

   assign {bus.pc_out, bus.instr_out, bus.exception_out,
           bus.exception_cause_out, bus.branch_predicted_taken_out}
          = w_valid_out ? w_head_pkt : '0;

endmodule
`default_nettype wire

// File: tb/tb_rv32_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32_fetch_buffer
// Brief    : Directed plus randomized bench against a queue-based packet model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32_fetch_buffer;
   import rv32_fetch_pkg::*;

   localparam int DEPTH    = 4;
   localparam int PC_WIDTH = 32;

   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   rv32_fetch_buffer_if #(.DEPTH(DEPTH), .PC_WIDTH(PC_WIDTH)) bus ();

   rv32_fetch_buffer #(.DEPTH(DEPTH), .PC_WIDTH(PC_WIDTH)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   rv32_fetch_packet_t q[$];
   bit                 after_flush;
   int                 n_pass;
   int                 n_fail;
   int                 n_total;

   logic               e_valid;
   logic               e_ready;
   int                 e_count;
   rv32_fetch_packet_t e_head;
   logic               o_valid;
   rv32_fetch_packet_t o_head;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model_expect(input rv32_fetch_packet_t in_pkt, input logic v, input logic fl);
      e_count = q.size();
      e_ready = (q.size() < DEPTH);
      if (fl)
         e_valid = 1'b0;
      else if (q.size() > 0)
         e_valid = 1'b1;
      else begin
`ifdef RV32_FETCH_BUFFER_BYPASS_EN
         e_valid = v && !after_flush;
`else
         e_valid = 1'b0;
`endif
      end
      e_head = '0;
      if (e_valid) e_head = (q.size() > 0) ? q[0] : in_pkt;
   endfunction

   function automatic void model_update(input rv32_fetch_packet_t in_pkt, input logic v,
                                        input logic rdy, input logic fl);
      bit take, accept, was_empty;
      if (fl) begin
         q.delete();
         after_flush = 1'b1;
      end else begin
         take      = e_valid && rdy;
         accept    = v && e_ready;
         was_empty = (q.size() == 0);
         if (take && !was_empty) q.delete(0);
         if (accept && !(take && was_empty)) q.push_back(in_pkt);
         after_flush = 1'b0;
      end
   endfunction

   task automatic step(input logic v, input logic [31:0] a_pc, input logic [31:0] a_ins,
                       input logic a_ex, input logic [3:0] a_ca, input logic a_bp,
                       input logic rdy, input logic fl);
      rv32_fetch_packet_t p;
      p = '{pc: a_pc, instr: a_ins, exception: a_ex, exception_cause: a_ca,
            branch_predicted_taken: a_bp};
      bus.valid_in                  = v;
      bus.pc_in                     = a_pc;
      bus.instr_in                  = a_ins;
      bus.exception_in              = a_ex;
      bus.exception_cause_in        = a_ca;
      bus.branch_predicted_taken_in = a_bp;
      bus.ready_in                  = rdy;
      bus.flush_in                  = fl;
      #3;
      model_expect(p, v, fl);
      o_valid = bus.valid_out;
      o_head  = '{pc: bus.pc_out, instr: bus.instr_out, exception: bus.exception_out,
                  exception_cause: bus.exception_cause_out,
                  branch_predicted_taken: bus.branch_predicted_taken_out};
      check("valid_out", 64'(o_valid), 64'(e_valid));
      check("pc_out", 64'(o_head.pc), 64'(e_head.pc));
      check("instr_out", 64'(o_head.instr), 64'(e_head.instr));
      check("exception_out", 64'(o_head.exception), 64'(e_head.exception));
      check("exception_cause_out", 64'(o_head.exception_cause), 64'(e_head.exception_cause));
      check("branch_pred_out", 64'(o_head.branch_predicted_taken), 64'(e_head.branch_predicted_taken));
      check("ready_out", 64'(bus.ready_out), 64'(e_ready));
      check("count_out", 64'(bus.count_out), 64'(e_count));
      check("empty_out", 64'(bus.empty_out), 64'(e_count == 0));
      check("full_out", 64'(bus.full_out), 64'(e_count == DEPTH));
      @(posedge clk);
      model_update(p, v, rdy, fl);
      #1;
   endtask

   task automatic idle(input logic rdy);
      step(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, rdy, 1'b0);
   endtask

   initial begin
      n_pass = 0; n_fail = 0; n_total = 0; after_flush = 1'b0;
      rst_n = 1'b0;
      bus.valid_in = 1'b0; bus.pc_in = '0; bus.instr_in = '0; bus.exception_in = 1'b0;
      bus.exception_cause_in = '0; bus.branch_predicted_taken_in = 1'b0;
      bus.ready_in = 1'b0; bus.flush_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid_out", 64'(bus.valid_out), 64'd0);
      check("rst_ready_out", 64'(bus.ready_out), 64'd1);
      check("rst_count_out", 64'(bus.count_out), 64'd0);
      check("rst_empty_out", 64'(bus.empty_out), 64'd1);
      check("rst_full_out", 64'(bus.full_out), 64'd0);
      check("rst_pc_out", 64'(bus.pc_out), 64'd0);
      rst_n = 1'b1;
      idle(1'b0);

      // Fill to full with decode stalled, then drain in order.
      for (int i = 0; i < 4; i++)
         step(1'b1, 32'h100 + 32'(4 * i), $urandom, 1'b0, 4'h0, 1'(i & 1), 1'b0, 1'b0);
      check("fill_full_out", 64'(bus.full_out), 64'd1);
      check("fill_ready_out", 64'(bus.ready_out), 64'd0);
      check("fill_count_out", 64'(bus.count_out), 64'd4);
      for (int i = 0; i < 4; i++) begin
         idle(1'b1);
         check("drain_pc_order", 64'(o_head.pc), 64'h100 + 64'(4 * i));
      end

      // Sustained push/pop at occupancy 2 across pointer wrap.
      step(1'b1, 32'h300, $urandom, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h304, $urandom, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 32'h308 + 32'(4 * i), $urandom, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
         check("stream_pc", 64'(o_head.pc), 64'h300 + 64'(4 * i));
         check("stream_count", 64'(bus.count_out), 64'd2);
      end
      idle(1'b1);
      check("stream_tail0", 64'(o_head.pc), 64'h328);
      idle(1'b1);
      check("stream_tail1", 64'(o_head.pc), 64'h32C);

      // Flush with three entries and a same-cycle push.
      for (int i = 0; i < 3; i++)
         step(1'b1, 32'h400 + 32'(4 * i), $urandom, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h999, $urandom, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
      check("flush_valid_cycle", 64'(o_valid), 64'd0);
      check("flush_count_next", 64'(bus.count_out), 64'd0);
      step(1'b1, 32'h40C, $urandom, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      check("flush_valid_after", 64'(o_valid), 64'd0);
      idle(1'b1);
      check("flush_next_pc", 64'(o_head.pc), 64'h40C);

      // Exception packet travels unmodified.
      step(1'b1, 32'h500, 32'h0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
      idle(1'b1);
      check("exc_valid", 64'(o_valid), 64'd1);
      check("exc_pc", 64'(o_head.pc), 64'h500);
      check("exc_instr", 64'(o_head.instr), 64'h0);
      check("exc_flag", 64'(o_head.exception), 64'd1);
      check("exc_cause", 64'(o_head.exception_cause), 64'd2);

      // Empty buffer with decode ready: bypass versus registered path.
      step(1'b1, 32'h200, 32'h13, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
`ifdef RV32_FETCH_BUFFER_BYPASS_EN
      check("bypass_same_cycle_pc", 64'(o_head.pc), 64'h200);
      check("bypass_count", 64'(bus.count_out), 64'd0);
`else
      check("nobypass_same_cycle_valid", 64'(o_valid), 64'd0);
      idle(1'b1);
      check("nobypass_next_pc", 64'(o_head.pc), 64'h200);
`endif

      // Asynchronous reset in the middle of a cycle with two entries held.
      step(1'b1, 32'h600, $urandom, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h604, $urandom, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      bus.valid_in = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", 64'(bus.valid_out), 64'd0);
      check("async_rst_count", 64'(bus.count_out), 64'd0);
      check("async_rst_empty", 64'(bus.empty_out), 64'd1);
      q.delete();
      after_flush = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1'b1);

      // Randomized traffic with varying decode stall density.
      for (int i = 0; i < 400; i++) begin
         logic v, rdy, fl;
         v   = ($urandom_range(0, 3) != 0);
         rdy = (i < 130) ? ($urandom_range(0, 3) == 0) :
               (i < 260) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
         fl  = ($urandom_range(0, 23) == 0);
         step(v, $urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), rdy, fl);
      end
      for (int i = 0; i < 2 * DEPTH; i++) idle(1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
